alu_req_scheduler: RTL and testbench

Shares one small ALU datapath between two independent requesters, each using a valid/ready handshake.
- Arbitrates round-robin and latches the winner's operands and opcode.
- Sequences execution: single-cycle ops, plus a multi-cycle iterative divide when compiled in.
- Returns a tagged, registered result through a valid/ready response port.
- Sits between the pin-level operand/opcode decode and the result output register of the top-level tile.

---
 rtl/alu_req_scheduler_if.sv | 55 +++++
 rtl/alu_req_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler_if
//   Bundles the two request channels and the response channel of the shared
//   ALU scheduler.
//
//   Handshake rule (applies to req0, req1 and rsp): a transfer happens on a
//   rising clk edge where valid && ready are both high. The producer holds its
//   payload stable while valid is high and not yet accepted. A producer may
//   drop valid before it is accepted.
//
//   Modports:
//     master : requester/consumer side (drives reqN_*, rsp_ready)
//     slave  : scheduler side (drives reqN_ready, rsp_valid/data/id/err)
//
//   Parameter OPW: operand width; response data is 2*OPW bits.
// ---------------------------------------------------------------------------
interface alu_req_scheduler_if #(
    parameter int OPW = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [OPW-1:0]     req0_a;
    logic [OPW-1:0]     req0_b;
    logic [2:0]         req0_op;

    logic               req1_valid;
    logic               req1_ready;
    logic [OPW-1:0]     req1_a;
    logic [OPW-1:0]     req1_b;
    logic [2:0]         req1_op;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*OPW-1:0]   rsp_data;
    logic               rsp_id;
    logic               rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
//   Shares one small ALU between two requesters. Round-robin arbitration in
//   IDLE, one-cycle execution in EXEC, optional iterative restoring divide in
//   DIV, and a registered, tagged response held in RESP until accepted.
//
//   Compile-time option:
//     ALU_SCHED_DIV_EN : when defined, op 3'b011 runs an OPW-cycle restoring
//                        divide (quotient, or all-ones + err on b==0). When
//                        undefined, op 3'b011 is an undefined opcode.
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous reset, active-high
//     bus        : alu_req_scheduler_if.slave (req0, req1, rsp channels)
//     busy       : state != IDLE
//     dbg_state  : current FSM state encoding (IDLE=0, EXEC=1, DIV=2, RESP=3)
//
//   Opcodes: 000 add, 001 sub (wraps), 010 and, 100 or, 101 mul,
//            011 divide (if built), others -> result 0 with err.
// ---------------------------------------------------------------------------
module alu_req_scheduler #(
    parameter int OPW = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_req_scheduler_if.slave  bus,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int RW = 2 * OPW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef ALU_SCHED_DIV_EN
        DIV  = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic [2:0]       op_code;
    logic             op_id;

    // ---------------------------------------------------------------
    // Arbitration: a lone valid wins; on a tie the requester that did
    // not win last time is granted.
    // ---------------------------------------------------------------
    logic             any_valid;
    logic             grant;
    logic [OPW-1:0]   sel_a;
    logic [OPW-1:0]   sel_b;
    logic [2:0]       sel_op;

    assign any_valid = bus.req0_valid | bus.req1_valid;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;
    assign sel_op = grant ? bus.req1_op : bus.req0_op;

    // Ready only while idle and only for the granted, valid requester,
    // so both can never be high together.
    assign bus.req0_ready = (state == IDLE) && any_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && any_valid &&  grant;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // ---------------------------------------------------------------
    // Single-cycle ALU on zero-extended operands.
    // ---------------------------------------------------------------
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    exec_data;
    logic             exec_err;

    assign a_ext = {{OPW{1'b0}}, op_a};
    assign b_ext = {{OPW{1'b0}}, op_b};

    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        case (op_code)
            3'b000:  exec_data = a_ext + b_ext;
            3'b001:  exec_data = a_ext - b_ext;
            3'b010:  exec_data = a_ext & b_ext;
            3'b100:  exec_data = a_ext | b_ext;
            3'b101:  exec_data = a_ext * b_ext;
            // 011 lands here only when the divider is not built.
            default: exec_err  = 1'b1;
        endcase
    end

`ifdef ALU_SCHED_DIV_EN
    // ---------------------------------------------------------------
    // Restoring divider: div_q starts as the dividend and is shifted
    // left one bit per cycle, each freed LSB receiving a quotient bit.
    // div_rem holds the partial remainder (always < divisor).
    // ---------------------------------------------------------------
    localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

    logic [OPW-1:0]   div_q;
    logic [OPW-1:0]   div_rem;
    logic [CW-1:0]    div_cnt;
    logic [OPW:0]     rem_shift;
    logic [OPW:0]     rem_diff;
    logic             rem_ge;
    logic [OPW-1:0]   q_next;
    logic [OPW-1:0]   rem_next;
    logic             div_unused;

    assign rem_shift  = {div_rem, div_q[OPW-1]};
    assign rem_ge     = (rem_shift >= {1'b0, op_b});
    assign rem_diff   = rem_shift - {1'b0, op_b};
    assign q_next     = {div_q[OPW-2:0], rem_ge};
    // When rem_ge is set the difference is below the divisor, so its top
    // bit is always zero and may be dropped.
    assign rem_next   = rem_ge ? rem_diff[OPW-1:0] : rem_shift[OPW-1:0];
    assign div_unused = rem_diff[OPW];
`endif

    // ---------------------------------------------------------------
    // Control FSM with registered response outputs.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= '0;
            op_id        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_err   <= 1'b0;
`ifdef ALU_SCHED_DIV_EN
            div_q        <= '0;
            div_rem      <= '0;
            div_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        op_code    <= sel_op;
                        op_id      <= grant;
                        last_grant <= grant;
`ifdef ALU_SCHED_DIV_EN
                        if (sel_op == 3'b011) begin
                            div_q   <= sel_a;
                            div_rem <= '0;
                            div_cnt <= '0;
                            state   <= DIV;
                        end else begin
                            state   <= EXEC;
                        end
`else
                        state      <= EXEC;
`endif
                    end
                end

                EXEC: begin
                    bus.rsp_data  <= exec_data;
                    bus.rsp_err   <= exec_err;
                    bus.rsp_id    <= op_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end

`ifdef ALU_SCHED_DIV_EN
                DIV: begin
                    div_q   <= q_next;
                    div_rem <= rem_next;
                    div_cnt <= div_cnt + 1'b1;
                    // The final quotient bit is folded straight into the
                    // response so the result appears after exactly OPW cycles.
                    if (div_cnt == CW'(OPW - 1)) begin
                        if (op_b == '0) begin
                            bus.rsp_data <= '1;
                            bus.rsp_err  <= 1'b1;
                        end else begin
                            bus.rsp_data <= {{OPW{1'b0}}, q_next};
                            bus.rsp_err  <= 1'b0;
                        end
                        bus.rsp_id    <= op_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
`endif

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_req_scheduler
//   Directed bench for alu_req_scheduler (OPW=4). Expected results are
//   hand-computed constants; the arbitration test uses an expected queue
//   checked by a response monitor. Build with +define+ALU_SCHED_DIV_EN to
//   exercise the divider.
// ---------------------------------------------------------------------------
module tb_alu_req_scheduler;

    localparam int OPW = 4;
    localparam int W   = 2 + 2 * OPW;   // {id, err, data}

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;
    logic         mon_en = 1'b0;

    alu_req_scheduler_if #(.OPW(OPW)) bus ();

    alu_req_scheduler #(.OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response handshake is compared against exp_q.
    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_rsp", 32'd1, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("sb_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_data}, exp_item);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
    endtask

    // Counts edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 50);
    endtask

    task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [7:0] exp_data,
                         input logic exp_err, input int exp_lat, input string tag);
        int lat;
        int w;
        @(negedge clk);
        drive_req(id, a, b, op);
        #1;
        w = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, "_other_ready"}, id ? bus.req0_ready : bus.req1_ready, 0);
        @(negedge clk);                       // accept edge has passed
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_drop"}, id ? bus.req1_ready : bus.req0_ready, 0);
        wait_rsp(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, bus.rsp_data, exp_data);
        check({tag, "_id"}, bus.rsp_id, id);
        check({tag, "_err"}, bus.rsp_err, exp_err);
        @(negedge clk);                       // handshake edge has passed
        check({tag, "_valid_clr"}, bus.rsp_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int  idx0, idx1, lat;
        logic acc0, acc1, seen;
        logic [3:0] a0 [4];
        logic [3:0] a1 [4];

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_data",  bus.rsp_data, 0);
        check("rst_id",    bus.rsp_id, 0);
        check("rst_err",   bus.rsp_err, 0);
        check("rst_busy",  busy, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // T1/T2: single-cycle ops
        do_op(1'b0, 4'd9,  4'd9,  3'b000, 8'h12, 1'b0, 1, "t1_add");
        do_op(1'b0, 4'd3,  4'd5,  3'b001, 8'hFE, 1'b0, 1, "t2_sub");
        do_op(1'b0, 4'd15, 4'd15, 3'b101, 8'hE1, 1'b0, 1, "t2_mul");
        do_op(1'b0, 4'd6,  4'd7,  3'b111, 8'h00, 1'b1, 1, "t2_bad");
        do_op(1'b1, 4'd12, 4'd10, 3'b010, 8'h08, 1'b0, 1, "t2_and");
        do_op(1'b1, 4'd5,  4'd3,  3'b110, 8'h00, 1'b1, 1, "t2_bad110");

        // T3: both requesters valid continuously right after reset
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            a0[k] = 4'(k + 1);                // req0: (k+1)+2
            a1[k] = 4'(k);                    // req1: k | 8
            exp_q.push_back({1'b0, 1'b0, 8'(k + 3)});
            exp_q.push_back({1'b1, 1'b0, 8'(k + 8)});
        end
        mon_en = 1'b1;
        idx0 = 0; idx1 = 0; acc0 = 1'b0; acc1 = 1'b0;
        @(negedge clk);
        drive_req(1'b0, a0[0], 4'd2, 3'b000);
        drive_req(1'b1, a1[0], 4'd8, 3'b100);
        #1;
        acc0 = bus.req0_valid && bus.req0_ready;
        acc1 = bus.req1_valid && bus.req1_ready;
        for (int cyc = 0; cyc < 200 && (idx0 < 4 || idx1 < 4); cyc++) begin
            @(negedge clk);
            if (acc0) begin
                idx0++;
                if (idx0 < 4) drive_req(1'b0, a0[idx0], 4'd2, 3'b000);
                else bus.req0_valid = 1'b0;
            end
            if (acc1) begin
                idx1++;
                if (idx1 < 4) drive_req(1'b1, a1[idx1], 4'd8, 3'b100);
                else bus.req1_valid = 1'b0;
            end
            #1;
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            if (bus.req0_ready && bus.req1_ready) check("t3_ready_excl", 32'd1, 32'd0);
        end
        check("t3_all_issued", idx0 + idx1, 8);
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) @(negedge clk);
        @(negedge clk);
        check("t3_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // T4: response back-pressure
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b1, 4'd1, 4'd2, 3'b000);
        #1;
        check("t4_ready1", bus.req1_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp(lat);
        check("t4_lat", lat, 1);
        drive_req(1'b0, 4'd2, 4'd2, 3'b000);
        drive_req(1'b1, 4'd4, 4'd4, 3'b000);
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", bus.rsp_valid, 1);
            check("t4_hold_data",  bus.rsp_data, 8'd3);
            check("t4_hold_id",    bus.rsp_id, 1);
            check("t4_hold_rdy0",  bus.req0_ready, 0);
            check("t4_hold_rdy1",  bus.req1_ready, 0);
            check("t4_hold_busy",  busy, 1);
        end
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        #1;
        check("t4_hs_rdy0", bus.req0_ready, 0);
        @(negedge clk);
        check("t4_after_valid", bus.rsp_valid, 0);
        check("t4_after_busy",  busy, 0);
        check("t4_after_state", dbg_state, 0);
        check("t4_after_data",  bus.rsp_data, 8'd3);
        bus.req0_valid = 1'b0;                // withdrawn before acceptance
        @(negedge clk);
        check("t4_drop_busy", busy, 0);

        // T5: divide
`ifdef ALU_SCHED_DIV_EN
        do_op(1'b0, 4'd13, 4'd4, 3'b011, 8'h03, 1'b0, OPW, "t5_div");
        do_op(1'b1, 4'd13, 4'd0, 3'b011, 8'hFF, 1'b1, OPW, "t5_div0");
        do_op(1'b0, 4'd15, 4'd1, 3'b011, 8'h0F, 1'b0, OPW, "t5_div1");
`else
        do_op(1'b0, 4'd13, 4'd4, 3'b011, 8'h00, 1'b1, 1, "t5_nodiv");
`endif

        // T6: reset in the middle of an operation
        do_op(1'b1, 4'd7, 4'd6, 3'b000, 8'h0D, 1'b0, 1, "t6_pre");
        @(negedge clk);
        drive_req(1'b0, 4'd13, 4'd4, 3'b011);
        #1;
        check("t6_ready0", bus.req0_ready, 1);
        @(negedge clk);                       // after accept edge
        bus.req0_valid = 1'b0;
        @(negedge clk);                       // second cycle of the op
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bus.rsp_valid, 0);
        check("t6_rst_data",  bus.rsp_data, 0);
        check("t6_rst_id",    bus.rsp_id, 0);
        check("t6_rst_err",   bus.rsp_err, 0);
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("t6_no_rsp", seen, 0);
        drive_req(1'b0, 4'd1, 4'd1, 3'b000);
        drive_req(1'b1, 4'd2, 4'd2, 3'b000);
        #1;
        check("t6_grant0", bus.req0_ready, 1);
        check("t6_grant1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(lat);
        check("t6_post_data", bus.rsp_data, 8'd2);
        check("t6_post_id",   bus.rsp_id, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
